// File: rtl/oled_ctrl.sv
// oled_ctrl: SSD1306 command/data sequencer feeding the OLED SPI transmitter.
// Runs the panel reset timing, sends the fixed init list, then sends a window
// command plus a 1024-byte frame from a synchronous frame buffer on REFRESH.
// One 10-bit word per transfer; the next word waits for SPI_DONE.
// Optional build macro: OLED_AUTO_REFRESH_EN (continuous back-to-back frames).
module oled_ctrl #(
    parameter int unsigned RES_LOW_CYCLES  = 250,
    parameter int unsigned RES_WAIT_CYCLES = 2500
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [9:0] SPI_DATA,
    output logic       SPI_START,
    input  logic       SPI_DONE,
    output logic       OLED_RES,
    output logic [9:0] FB_ADDR,
    input  logic [7:0] FB_DATA,
    input  logic       REFRESH,
    output logic       READY,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    typedef enum logic [3:0] {
        S_RES_LOW, S_RES_WAIT, S_INIT_ISSUE, S_INIT_WAIT, S_IDLE,
        S_WIN_ISSUE, S_WIN_WAIT, S_FB_FETCH, S_FB_ISSUE, S_FB_WAIT
    } state_t;

    localparam logic [15:0] LOW_LAST  = 16'(RES_LOW_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(RES_WAIT_CYCLES - 1);
    localparam logic [4:0]  INIT_LAST = 5'd24;
    localparam logic [4:0]  WIN_LAST  = 5'd5;
    localparam logic [9:0]  FB_LAST   = 10'd1023;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [4:0]  idx;
    logic        pending;

    logic low_done, wait_done, init_last, win_last, fb_last;

    // SSD1306 power-up command list
    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
            5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
            5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
            5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
            5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
            5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
            5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
            5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
            5'd24: return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    // Full-screen window: columns 0..127, pages 0..7
    function automatic logic [7:0] win_byte(input logic [4:0] i);
        case (i)
            5'd0: return 8'h21;  5'd1: return 8'h00;  5'd2: return 8'h7F;
            5'd3: return 8'h22;  5'd4: return 8'h00;  5'd5: return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    assign low_done  = (state == S_RES_LOW)   && (cnt == LOW_LAST);
    assign wait_done = (state == S_RES_WAIT)  && (cnt == WAIT_LAST);
    assign init_last = (state == S_INIT_WAIT) && SPI_DONE && (idx == INIT_LAST);
    assign win_last  = (state == S_WIN_WAIT)  && SPI_DONE && (idx == WIN_LAST);
    assign fb_last   = (state == S_FB_WAIT)   && SPI_DONE && (FB_ADDR == FB_LAST);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_RES_LOW;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_RES_LOW:    if (low_done)  state_nxt = S_RES_WAIT;
            S_RES_WAIT:   if (wait_done) state_nxt = S_INIT_ISSUE;
            S_INIT_ISSUE: state_nxt = S_INIT_WAIT;
            S_INIT_WAIT:
                if (SPI_DONE) begin
`ifdef OLED_AUTO_REFRESH_EN
                    state_nxt = init_last ? S_WIN_ISSUE : S_INIT_ISSUE;
`else
                    state_nxt = init_last ? S_IDLE : S_INIT_ISSUE;
`endif
                end
            S_IDLE: begin
`ifdef OLED_AUTO_REFRESH_EN
                state_nxt = S_WIN_ISSUE;
`else
                if (REFRESH || pending) state_nxt = S_WIN_ISSUE;
`endif
            end
            S_WIN_ISSUE:  state_nxt = S_WIN_WAIT;
            S_WIN_WAIT:
                if (SPI_DONE) state_nxt = win_last ? S_FB_FETCH : S_WIN_ISSUE;
            S_FB_FETCH:   state_nxt = S_FB_ISSUE;
            S_FB_ISSUE:   state_nxt = S_FB_WAIT;
            S_FB_WAIT:
                if (SPI_DONE) begin
`ifdef OLED_AUTO_REFRESH_EN
                    state_nxt = fb_last ? S_WIN_ISSUE : S_FB_FETCH;
`else
                    state_nxt = fb_last ? S_IDLE : S_FB_FETCH;
`endif
                end
            default:      state_nxt = S_RES_LOW;
        endcase
    end

    // Outputs decoded from state; only ISSUE states drive a word
    always_comb begin
        SPI_START = 1'b0;
        SPI_DATA  = 10'h300;
        BUSY      = (state != S_IDLE);
        case (state)
            S_INIT_ISSUE: begin
                SPI_START = 1'b1;
                SPI_DATA  = {2'b00, init_byte(idx)};
            end
            S_WIN_ISSUE: begin
                SPI_START = 1'b1;
                SPI_DATA  = {2'b00, win_byte(idx)};
            end
            S_FB_ISSUE: begin
                SPI_START = 1'b1;
                SPI_DATA  = {2'b01, FB_DATA};
            end
            default: ;
        endcase
    end

    // Reset-timing counter, only runs during the two reset phases
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                      cnt <= '0;
        else if (low_done || wait_done)  cnt <= '0;
        else if (state == S_RES_LOW || state == S_RES_WAIT) cnt <= cnt + 16'd1;
        else                             cnt <= '0;
    end

    // List index: advances on each command-list SPI_DONE, parked at 0 elsewhere
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) idx <= '0;
        else begin
            case (state)
                S_INIT_WAIT: if (SPI_DONE) idx <= init_last ? 5'd0 : idx + 5'd1;
                S_WIN_WAIT:  if (SPI_DONE) idx <= win_last  ? 5'd0 : idx + 5'd1;
                S_INIT_ISSUE, S_WIN_ISSUE: idx <= idx;
                default:     idx <= '0;
            endcase
        end
    end

    // Frame buffer address: one step per frame byte, back to 0 after the last
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                  FB_ADDR <= '0;
        else if (state == S_WIN_WAIT)                FB_ADDR <= '0;
        else if (state == S_FB_WAIT && SPI_DONE)     FB_ADDR <= fb_last ? 10'd0 : FB_ADDR + 10'd1;
    end

    // Panel reset pin, init-complete flag and end-of-frame pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OLED_RES   <= 1'b0;
            READY      <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            if (low_done)  OLED_RES <= 1'b1;
            if (init_last) READY    <= 1'b1;
            FRAME_DONE <= fb_last;
        end
    end

    // Single-deep refresh request latch; consumed when leaving S_IDLE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pending <= 1'b0;
`ifdef OLED_AUTO_REFRESH_EN
        else        pending <= 1'b0;
`else
        else if (state == S_IDLE) pending <= 1'b0;
        else if (REFRESH)         pending <= 1'b1;
`endif
    end

endmodule

// File: tb/tb_oled_ctrl.sv
// tb_oled_ctrl: directed bench for oled_ctrl (default build). Word lists are
// held in tables; a responder returns SPI_DONE a fixed delay after each START
// and records every issued word for comparison.
module tb_oled_ctrl;

    localparam int RL = 4;
    localparam int RW = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       SPI_DONE = 1'b0;
    logic       REFRESH = 1'b0;
    logic [7:0] FB_DATA;
    logic [9:0] SPI_DATA, FB_ADDR;
    logic       SPI_START, OLED_RES, READY, BUSY, FRAME_DONE;

    oled_ctrl #(.RES_LOW_CYCLES(RL), .RES_WAIT_CYCLES(RW)) dut (
        .CLK(CLK), .RST_N(RST_N), .SPI_DATA(SPI_DATA), .SPI_START(SPI_START),
        .SPI_DONE(SPI_DONE), .OLED_RES(OLED_RES), .FB_ADDR(FB_ADDR),
        .FB_DATA(FB_DATA), .REFRESH(REFRESH), .READY(READY), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // Synchronous frame buffer whose contents equal addr[7:0]
    always @(posedge CLK) FB_DATA <= FB_ADDR[7:0];

    typedef struct {
        int         idx;
        logic [9:0] word;
    } vec_t;

    vec_t init_tbl [25];
    vec_t win_tbl  [6];

    int         lat = 20;
    int         cap_n = 0;
    logic [9:0] cap [0:4095];
    int         fd_cnt = 0;
    int         overlap = 0;
    int         rsp_cnt = 0;
    bit         outstanding = 1'b0;

    int errors = 0;
    int checks = 0;

    // SPI responder and word recorder
    always @(negedge CLK) begin
        if (!RST_N) begin
            outstanding <= 1'b0;
            rsp_cnt     <= 0;
            SPI_DONE    <= 1'b0;
        end else begin
            SPI_DONE <= 1'b0;
            if (rsp_cnt == 1) begin
                SPI_DONE    <= 1'b1;
                outstanding <= 1'b0;
                rsp_cnt     <= 0;
            end else if (rsp_cnt > 1) begin
                rsp_cnt <= rsp_cnt - 1;
            end
            if (SPI_START) begin
                if (outstanding) overlap <= overlap + 1;
                outstanding       <= 1'b1;
                rsp_cnt           <= lat;
                cap[cap_n % 4096] <= SPI_DATA;
                cap_n             <= cap_n + 1;
            end
            if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cap(input int n, input int budget, input string nm);
        int k = 0;
        while (cap_n < n && k < budget) begin @(negedge CLK); k++; end
        chk(nm, 32'(cap_n >= n), 1);
    endtask

    task automatic wait_ready(input int budget, input string nm);
        int k = 0;
        while (!READY && k < budget) begin @(negedge CLK); k++; end
        chk(nm, 32'(READY), 1);
    endtask

    task automatic wait_fd(input int n, input int budget, input string nm);
        int k = 0;
        while (fd_cnt < n && k < budget) begin @(negedge CLK); k++; end
        chk(nm, 32'(fd_cnt), 32'(n));
    endtask

    task automatic check_init(input int base);
        for (int i = 0; i < 25; i++)
            chk($sformatf("init_word%0d", init_tbl[i].idx), 32'(cap[(base + i) % 4096]), 32'(init_tbl[i].word));
    endtask

    task automatic check_frame(input int base, input string nm);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_win%0d", nm, win_tbl[i].idx), 32'(cap[(base + i) % 4096]), 32'(win_tbl[i].word));
        for (int a = 0; a < 1024; a++) begin
            logic [9:0] exp;
            exp = 10'h100 | 10'(a % 256);
            chk($sformatf("%s_byte%0d", nm, a), 32'(cap[(base + 6 + a) % 4096]), 32'(exp));
        end
    endtask

    int b1, b3, b4;

    initial begin
        logic [7:0] ib [25];
        logic [7:0] wb [6];
        ib = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
               8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
               8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        wb = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        for (int i = 0; i < 25; i++) init_tbl[i] = '{i, {2'b00, ib[i]}};
        for (int i = 0; i < 6; i++)  win_tbl[i]  = '{i, {2'b00, wb[i]}};

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_spi_data", 32'(SPI_DATA), 32'h300);
        chk("rst_spi_start", 32'(SPI_START), 0);
        chk("rst_oled_res", 32'(OLED_RES), 0);
        chk("rst_fb_addr", 32'(FB_ADDR), 0);
        chk("rst_ready", 32'(READY), 0);
        chk("rst_busy", 32'(BUSY), 1);
        chk("rst_frame_done", 32'(FRAME_DONE), 0);

        // Power-on timing and init list
        RST_N = 1'b1;
        repeat (RL - 1) @(posedge CLK);
        #1 chk("oled_res_still_low", 32'(OLED_RES), 0);
        @(posedge CLK);
        #1 chk("oled_res_rise", 32'(OLED_RES), 1);
        wait_ready(3000, "init_ready_timeout");
        check_init(0);
        chk("init_count", 32'(cap_n), 25);
        chk("idle_not_busy", 32'(BUSY), 0);

        // Frame on REFRESH, with three extra REFRESH pulses mid-frame
        @(negedge CLK);
        REFRESH = 1'b1;
        b1 = cap_n;
        @(negedge CLK);
        REFRESH = 1'b0;
        chk("refresh_start_1cyc", 32'(SPI_START), 1);
        chk("refresh_first_word", 32'(SPI_DATA), 32'h021);
        wait_cap(b1 + 100, 5000, "frame1_progress_timeout");
        for (int p = 0; p < 3; p++) begin
            @(negedge CLK) REFRESH = 1'b1;
            @(negedge CLK) REFRESH = 1'b0;
            repeat (5) @(negedge CLK);
        end
        lat = 4;
        wait_fd(1, 40000, "frame1_done");
        check_frame(b1, "f1");
        wait_fd(2, 20000, "frame2_done");
        check_frame(b1 + 1030, "f2");
        repeat (50) @(negedge CLK);
        chk("collapsed_one_frame", 32'(fd_cnt), 2);
        chk("frame_word_count", 32'(cap_n - b1), 2060);
        chk("idle_after_frames", 32'(BUSY), 0);
        chk("fb_addr_back_to_0", 32'(FB_ADDR), 0);

        // Reset mid-frame at byte 500
        @(negedge CLK) REFRESH = 1'b1;
        b3 = cap_n;
        @(negedge CLK) REFRESH = 1'b0;
        wait_cap(b3 + 507, 10000, "frame3_progress_timeout");
        chk("byte500_word", 32'(cap[(b3 + 506) % 4096]), 32'h1F4);
        RST_N = 1'b0;
        #1;
        chk("midrst_oled_res", 32'(OLED_RES), 0);
        chk("midrst_ready", 32'(READY), 0);
        chk("midrst_spi_start", 32'(SPI_START), 0);
        chk("midrst_busy", 32'(BUSY), 1);
        chk("midrst_fb_addr", 32'(FB_ADDR), 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        b4 = cap_n;

        // REFRESH during the repeated init: frame must follow READY at once
        repeat (6) @(negedge CLK);
        REFRESH = 1'b1;
        @(negedge CLK) REFRESH = 1'b0;
        wait_ready(3000, "reinit_ready_timeout");
        @(negedge CLK);
        chk("pending_start_after_ready", 32'(SPI_START), 1);
        chk("pending_first_word", 32'(SPI_DATA), 32'h021);
        check_init(b4);
        wait_fd(3, 20000, "frame4_done");
        check_frame(b4 + 25, "f4");
        chk("no_start_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oled_ctrl.md
# oled_ctrl

Command/data sequencer sitting directly upstream of the OLED SPI transmitter. Drives the panel reset pin through its power-on timing, streams the fixed SSD1306 init sequence, then on request sends a window command and a full 128x64 frame (1024 bytes) read from a synchronous frame buffer. Emits one 10-bit word per SPI transfer and waits for the transmitter's completion pulse before issuing the next.

## Interface
- RES_LOW_CYCLES, 250: CLK cycles OLED_RES held low after reset (10 us at 25 MHz); 1..65535.
- RES_WAIT_CYCLES, 2500: CLK cycles after OLED_RES rises before first command; 1..65535.
- CLK  in  1  system clock. One clock; reset is asynchronous and active-low.
- RST_N  in  1  asynchronous active-low reset.
- SPI_DATA  out  10  word to transmitter: [9]=CS level (always 0 when issued), [8]=DC (0 command, 1 data), [7:0] byte.
- SPI_START  out  1  one-cycle request; SPI_DATA valid in same cycle.
- SPI_DONE  in  1  one-cycle completion pulse from transmitter.
- OLED_RES  out  1  panel reset, active low.
- FB_ADDR  out  10  frame buffer byte address (page*128 + column).
- FB_DATA  in  8  frame buffer read data, valid one cycle after FB_ADDR.
- REFRESH  in  1  one-cycle frame send request.
- READY  out  1  high once init sequence complete.
- BUSY  out  1  high whenever not in S_IDLE.
- FRAME_DONE  out  1  one-cycle pulse after last frame byte's SPI_DONE.

## Operation
- Reset values: SPI_DATA=10'h300, SPI_START=0, OLED_RES=0, FB_ADDR=0, READY=0, BUSY=1, FRAME_DONE=0, pending=0, state S_RES_LOW.
- S_RES_LOW: count RES_LOW_CYCLES, then OLED_RES<=1 -> S_RES_WAIT.
- S_RES_WAIT: count RES_WAIT_CYCLES -> S_INIT_ISSUE, index 0.
- Init list, 25 command bytes (DC=0), in order: AE, D5, 80, A8, 3F, D3, 00, 40, 8D, 14, 20, 00, A1, C8, DA, 12, 81, CF, D9, F1, DB, 40, A4, A6, AF.
- S_INIT_ISSUE: SPI_START=1, SPI_DATA={1'b0,1'b0,list[idx]} -> S_INIT_WAIT. S_INIT_WAIT: on SPI_DONE, idx==24 -> READY<=1, S_IDLE; else idx+1, S_INIT_ISSUE.
- S_IDLE: REFRESH or pending -> clear pending, S_WIN_ISSUE, idx 0.
- Window list, 6 command bytes: 21, 00, 7F, 22, 00, 07. S_WIN_ISSUE/S_WIN_WAIT as init; after 6th SPI_DONE -> S_FB_FETCH, FB_ADDR=0.
- S_FB_FETCH: FB_ADDR presented -> S_FB_ISSUE. S_FB_ISSUE: SPI_START=1, SPI_DATA={1'b0,1'b1,FB_DATA} -> S_FB_WAIT.
- S_FB_WAIT: on SPI_DONE: FB_ADDR==1023 -> FRAME_DONE=1, FB_ADDR<=0, S_IDLE; else FB_ADDR+1, S_FB_FETCH.
- REFRESH while BUSY (incl. init): sets pending (single-deep; multiple collapse to one). REFRESH coinciding with FRAME_DONE: pending set, next frame starts from S_IDLE.
- SPI_DONE outside a WAIT state ignored.
- RST_N low at any time: all outputs to reset values, power-on sequence restarts; in-flight byte abandoned.

## Timing
- SPI_START is exactly one cycle, only in ISSUE states; never two STARTs without an intervening SPI_DONE.
- SPI_DONE -> next SPI_START: 1 cycle (command lists), 2 cycles (frame bytes, via FETCH).
- REFRESH in S_IDLE -> first SPI_START: 1 cycle.
- OLED_RES rises RES_LOW_CYCLES cycles after RST_N deasserts; first init SPI_START RES_WAIT_CYCLES cycles after OLED_RES rises (±1).
- Counters 16 bit; byte index 5 bit; FB_ADDR 10 bit, no wrap past 1023.

## Configuration
- OLED_AUTO_REFRESH_EN defined: after init and after every FRAME_DONE, controller re-enters S_WIN_ISSUE directly (continuous refresh); REFRESH ignored, pending never set; BUSY stays 1.
- Undefined: frames sent only on REFRESH/pending as above.

## Test plan
- Reset, RES_LOW=4, RES_WAIT=8, SPI model returns SPI_DONE 20 cycles after START -> OLED_RES rises at cycle 4, 25 STARTs with DATA 0x0AE..0x0AF in list order, DC=0, READY=1 after 25th DONE.
- After READY, pulse REFRESH, FB holds addr[7:0] -> 6 window words (0x021..0x007) then 1024 words 0x100|addr[7:0], FRAME_DONE one pulse, BUSY=0.
- REFRESH pulsed 3 times during frame -> exactly one further frame follows.
- REFRESH during init -> frame sent immediately after READY.
- RST_N low mid-frame at byte 500 -> OLED_RES=0, READY=0, SPI_START=0; full init repeats.
- OLED_AUTO_REFRESH_EN defined -> back-to-back frames, 1030 STARTs per FRAME_DONE pulse, no REFRESH needed.
